// File: rtl/updown_counter_n_if.sv
// Control and status bundle for updown_counter_n.
// The bench or parent drives the master side; the counter sits on the slave side.
interface updown_counter_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             sclr;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output en, up, load, load_val, sclr,
        input  out, tc, wrap, ovf
    );

    modport slave (
        input  en, up, load, load_val, sclr,
        output out, tc, wrap, ovf
    );
endinterface

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter with load, synchronous clear, programmable terminal
// value, wrap or saturate at the ends, and terminal-count/wrap/overflow flags.
module updown_counter_n #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic               clk,
    input  logic               clr,
    updown_counter_n_if.slave  bus
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_zero;

    assign at_max  = (cnt_q == MAX_V);
    assign at_zero = (cnt_q == '0);

    // Next state, priority sclr > load > en; an end event raises wrap and ovf.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        if (bus.sclr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            cnt_d = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_max) begin
                    cnt_d  = SATURATE ? cnt_q : '0;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    cnt_d  = SATURATE ? cnt_q : MAX_V;
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    // tc looks ahead: it flags that the coming edge is an end event.
    assign bus.tc   = bus.en & ((bus.up & at_max) | (~bus.up & at_zero));
    assign bus.out  = cnt_q;
    assign bus.wrap = wrap_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_updown_counter_n.sv
// Scoreboard bench for updown_counter_n: three instances (default, MAX 9 wrap, MAX 9 saturate).
module tb_updown_counter_n;
    typedef struct packed {
        logic [7:0] out;
        logic       wrap;
        logic       ovf;
    } exp_t;

    logic clk;
    logic clr_a, clr_b, clr_c;
    int   checks;
    int   errors;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    exp_t ea, eb, ec;

    updown_counter_n_if #(.WIDTH(8)) ia ();
    updown_counter_n_if #(.WIDTH(8)) ib ();
    updown_counter_n_if #(.WIDTH(8)) ic ();

    updown_counter_n #(.WIDTH(8)) dut_a (
        .clk (clk),
        .clr (clr_a),
        .bus (ia.slave)
    );

    updown_counter_n #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b0)) dut_b (
        .clk (clk),
        .clr (clr_b),
        .bus (ib.slave)
    );

    updown_counter_n #(.WIDTH(8), .MAX_COUNT(9), .SATURATE(1'b1)) dut_c (
        .clk (clk),
        .clr (clr_c),
        .bus (ic.slave)
    );

    // Rising edges at 10, 20, ...; inputs change on falling edges.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitors: one expected record is consumed per rising edge while the queue is non-empty.
    always @(posedge clk) begin
        #1;
        if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            cmp("a_out", 32'(ia.out), 32'(ea.out));
            cmp("a_wrap", 32'(ia.wrap), 32'(ea.wrap));
            cmp("a_ovf", 32'(ia.ovf), 32'(ea.ovf));
        end
        if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            cmp("b_out", 32'(ib.out), 32'(eb.out));
            cmp("b_wrap", 32'(ib.wrap), 32'(eb.wrap));
            cmp("b_ovf", 32'(ib.ovf), 32'(eb.ovf));
        end
        if (q_c.size() > 0) begin
            ec = q_c.pop_front();
            cmp("c_out", 32'(ic.out), 32'(ec.out));
            cmp("c_wrap", 32'(ic.wrap), 32'(ec.wrap));
            cmp("c_ovf", 32'(ic.ovf), 32'(ec.ovf));
        end
    end

    // Called on a falling edge with inputs already set: checks tc, queues the post-edge expectation.
    task automatic step(input int d, input logic [7:0] o, input logic w, input logic ov,
                        input logic tce);
        exp_t e;
        e.out  = o;
        e.wrap = w;
        e.ovf  = ov;
        #1;
        case (d)
            0: begin cmp("a_tc", 32'(ia.tc), 32'(tce)); q_a.push_back(e); end
            1: begin cmp("b_tc", 32'(ib.tc), 32'(tce)); q_b.push_back(e); end
            default: begin cmp("c_tc", 32'(ic.tc), 32'(tce)); q_c.push_back(e); end
        endcase
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
        ia.en = 1'b0; ia.up = 1'b1; ia.load = 1'b0; ia.load_val = '0; ia.sclr = 1'b0;
        ib.en = 1'b0; ib.up = 1'b1; ib.load = 1'b0; ib.load_val = '0; ib.sclr = 1'b0;
        ic.en = 1'b0; ic.up = 1'b1; ic.load = 1'b0; ic.load_val = '0; ic.sclr = 1'b0;

        // Reset state, including across a rising edge while clr is low.
        #1;
        cmp("rst_a_out", 32'(ia.out), 32'd0);
        cmp("rst_a_wrap", 32'(ia.wrap), 32'd0);
        cmp("rst_a_ovf", 32'(ia.ovf), 32'd0);
        cmp("rst_b_out", 32'(ib.out), 32'd0);
        cmp("rst_c_out", 32'(ic.out), 32'd0);
        ia.en = 1'b1;
        #10;
        cmp("rst_hold_a_out", 32'(ia.out), 32'd0);

        // Test 1: release at t=15, count up through 255 -> 0.
        #4;
        clr_a = 1'b1; clr_b = 1'b1; clr_c = 1'b1;
        ia.en = 1'b1; ia.up = 1'b1;
        for (int k = 1; k <= 260; k++) begin
            step(0, 8'(k % 256), (k == 256), (k >= 256), (k == 256));
        end
        ia.en = 1'b0;

        // Test 2: MAX 9 wrap mode, down from 0.
        ib.en = 1'b1; ib.up = 1'b0;
        step(1, 8'd9, 1'b1, 1'b1, 1'b1);
        step(1, 8'd8, 1'b0, 1'b1, 1'b0);
        step(1, 8'd7, 1'b0, 1'b1, 1'b0);
        step(1, 8'd6, 1'b0, 1'b1, 1'b0);
        ib.en = 1'b0;

        // Test 3: MAX 9 saturate mode, up from 7 then reverse.
        ic.load = 1'b1; ic.load_val = 8'd7;
        step(2, 8'd7, 1'b0, 1'b0, 1'b0);
        ic.load = 1'b0; ic.en = 1'b1; ic.up = 1'b1;
        step(2, 8'd8, 1'b0, 1'b0, 1'b0);
        step(2, 8'd9, 1'b0, 1'b0, 1'b0);
        step(2, 8'd9, 1'b1, 1'b1, 1'b1);
        step(2, 8'd9, 1'b1, 1'b1, 1'b1);
        ic.up = 1'b0;
        step(2, 8'd8, 1'b0, 1'b1, 1'b0);

        // Test 4: load above MAX clamps; sclr beats load.
        ic.en = 1'b0; ic.load = 1'b1; ic.load_val = 8'd200;
        step(2, 8'd9, 1'b0, 1'b1, 1'b0);
        ic.sclr = 1'b1;
        step(2, 8'd0, 1'b0, 1'b0, 1'b0);
        ic.sclr = 1'b0; ic.load = 1'b0;

        // Test 5: hold at 4 with en low, then async clear mid-cycle.
        ib.load = 1'b1; ib.load_val = 8'd4;
        step(1, 8'd4, 1'b0, 1'b1, 1'b0);
        ib.load = 1'b0;
        for (int k = 0; k < 5; k++) step(1, 8'd4, 1'b0, 1'b1, 1'b0);
        #2;
        clr_b = 1'b0;
        #1;
        cmp("b_async_out", 32'(ib.out), 32'd0);
        cmp("b_async_wrap", 32'(ib.wrap), 32'd0);
        cmp("b_async_ovf", 32'(ib.ovf), 32'd0);
        @(negedge clk);
        clr_b = 1'b1; ib.en = 1'b1; ib.up = 1'b1;
        step(1, 8'd1, 1'b0, 1'b0, 1'b0);
        ib.en = 1'b0;

        // Test 6: direction toggles every cycle from 5, ovf left set from test 1.
        ia.load = 1'b1; ia.load_val = 8'd5;
        step(0, 8'd5, 1'b0, 1'b1, 1'b0);
        ia.load = 1'b0; ia.en = 1'b1;
        ia.up = 1'b1; step(0, 8'd6, 1'b0, 1'b1, 1'b0);
        ia.up = 1'b0; step(0, 8'd5, 1'b0, 1'b1, 1'b0);
        ia.up = 1'b1; step(0, 8'd6, 1'b0, 1'b1, 1'b0);
        ia.up = 1'b0; step(0, 8'd5, 1'b0, 1'b1, 1'b0);
        // sclr takes priority over en and clears ovf.
        ia.sclr = 1'b1;
        step(0, 8'd0, 1'b0, 1'b0, 1'b0);
        ia.sclr = 1'b0; ia.en = 1'b0;

        @(negedge clk);
        @(negedge clk);
        cmp("q_a_drained", 32'(q_a.size()), 32'd0);
        cmp("q_b_drained", 32'(q_b.size()), 32'd0);
        cmp("q_c_drained", 32'(q_c.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/updown_counter_n.md
Name: updown_counter_n

Overview:
Parametrised successor to the team's free-running N-bit counter. Adds:
- up/down direction, count enable, parallel load, synchronous clear
- programmable terminal value, wrap or saturate mode
- terminal-count, wrap-pulse and sticky overflow flags

Used as the general counter/timer primitive in Digital-Design blocks and benches.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MAX_COUNT, 2**WIDTH-1, terminal value; count range 0..MAX_COUNT; must be <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at ends; 1 = hold at ends

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load
load_val  input  WIDTH  value for load
sclr  input  1  synchronous clear, active-high
out  output  WIDTH  registered count
tc  output  1  combinational terminal-count indicator
wrap  output  1  registered one-cycle end-event pulse
ovf  output  1  registered sticky overflow/underflow flag

Behaviour:
- Reset (clr=0, asynchronous): out=0, wrap=0, ovf=0, immediately, independent of clk.
- Reset release: synchronous to the next rising edge, i.e. first update on the first edge with clr=1.
- Per rising edge, priority sclr > load > en.
- sclr=1: out<=0, wrap<=0, ovf<=0.
- load=1 (sclr=0): out<=min(load_val, MAX_COUNT); wrap<=0; ovf unchanged.
- en=1, up=1, out<MAX_COUNT: out<=out+1; wrap<=0.
- en=1, up=1, out==MAX_COUNT (end event):
  - SATURATE=0: out<=0.
  - SATURATE=1: out holds.
  - Both modes: wrap<=1, ovf<=1.
- en=1, up=0, out>0: out<=out-1; wrap<=0.
- en=1, up=0, out==0 (end event):
  - SATURATE=0: out<=MAX_COUNT.
  - SATURATE=1: out holds.
  - Both modes: wrap<=1, ovf<=1.
- en=0 (no sclr/load): out holds; wrap<=0.
- wrap is high for exactly the one cycle following each end event. Consecutive end events (saturate mode, en held) keep wrap high on each of those cycles.
- ovf stays 1 until clr or sclr.
- tc = en & ((up & out==MAX_COUNT) | (~up & out==0)). Combinational, so it anticipates the end event on the same edge.
- Direction may change on any cycle; the next step uses the new up value. No pipeline, latency 1 cycle from input to out.
- Arithmetic is unsigned, modulo MAX_COUNT+1 in wrap mode. out never exceeds MAX_COUNT in any mode, including after load.
- Reset asserted mid-count: all outputs clear asynchronously. No state survives.

Test Plan:
1. Defaults (WIDTH=8); clr=0 for 15 time units, then clr=1, en=1, up=1; run 260 cycles -> out 0,1,…,255,0. wrap=1 only in the cycle after 255->0. tc=1 while out==255. ovf=1 thereafter.
2. MAX_COUNT=9, SATURATE=0; up=0 from out=0 -> out=9, wrap pulse 1 cycle. Continue down -> 8,7,…
3. MAX_COUNT=9, SATURATE=1; count up from 7 -> 8,9,9,9. wrap high for each held cycle. Then up=0 -> 8.
4. load=1, load_val=200 with MAX_COUNT=9 -> out=9. load and sclr asserted together -> out=0, ovf=0.
5. en=0 for 5 cycles at out=4 -> out stays 4, tc=0, wrap=0. Assert clr=0 mid-cycle -> out=0 before the next edge.
6. Toggle up every cycle from out=5 with en=1 -> out alternates 6,5,6,5. No wrap, ovf unchanged.
